mux_nto1_scan: RTL and testbench

//  Parametrised N-channel, W-bit registered multiplexer with an output valid/ready handshake.
//  - Manual mode: a start pulse emits one beat from a chosen channel.
//  - Scan mode: a start pulse emits every channel in order, channel 0..NUM_CH-1, one beat each.

---
 rtl/mux_scan_pkg.sv | 12 +
 rtl/mux_nto1_sel.sv | 22 ++
 rtl/mux_nto1_scan.sv | 141 ++++++++++++++
 tb/tb_mux_nto1_scan.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the N:1 registered scan multiplexer.
package mux_scan_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/mux_nto1_sel.sv
// Combinational channel selector: picks one DATA_W word out of a flattened bus.
module mux_nto1_sel #(
  parameter int unsigned NUM_CH = 32,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned SEL_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH*DATA_W-1:0] din_i,
  input  logic [SEL_W-1:0]         idx_i,
  output logic [DATA_W-1:0]        word_o
);

  // Out-of-range indices yield zero; callers never load such a word.
  always_comb begin
    word_o = '0;
    for (int k = 0; k < int'(NUM_CH); k++) begin
      if (idx_i == SEL_W'(k)) begin
        word_o = din_i[k*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/mux_nto1_scan.sv
// N-channel registered mux with valid/ready output, manual and scan modes.
// Optional feature macro: MUX_SCAN_PARITY_EN adds out_par = ^out_data.
module mux_nto1_scan
  import mux_scan_pkg::*;
#(
  parameter int unsigned NUM_CH = 32,
  parameter int unsigned DATA_W = 8,
  localparam int unsigned SEL_W = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH*DATA_W-1:0] din,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel_in,
  input  logic                     start,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_ch,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     done,
  output logic                     err
`ifdef MUX_SCAN_PARITY_EN
  ,
  output logic                     out_par
`endif
);

  state_e             state_q, state_d;
  logic               mode_q, mode_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [SEL_W-1:0]   ch_q, ch_d;
  logic               valid_q, valid_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [SEL_W-1:0]   next_idx;
  logic [DATA_W-1:0]  next_word;
  logic               last_ch;

  // In IDLE the candidate is the start channel; in SEND it is the following scan channel.
  always_comb begin
    if (state_q == IDLE) begin
      next_idx = (mode == MODE_SCAN) ? '0 : sel_in;
    end else begin
      next_idx = ch_q + SEL_W'(1);
    end
  end

  mux_nto1_sel #(
    .NUM_CH (NUM_CH),
    .DATA_W (DATA_W),
    .SEL_W  (SEL_W)
  ) u_sel (
    .din_i  (din),
    .idx_i  (next_idx),
    .word_o (next_word)
  );

  assign last_ch = (ch_q == SEL_W'(NUM_CH - 1));

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    data_d  = data_q;
    ch_d    = ch_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (mode == MODE_SCAN || 32'(sel_in) < NUM_CH) begin
            state_d = SEND;
            mode_d  = mode;
            data_d  = next_word;
            ch_d    = next_idx;
            valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SEND: begin
        if (out_ready) begin
          if (mode_q == MODE_MANUAL || last_ch) begin
            state_d = IDLE;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            data_d = next_word;
            ch_d   = next_idx;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= MODE_MANUAL;
      data_q  <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

`ifdef MUX_SCAN_PARITY_EN
  logic par_q;

  // Tracks data_q exactly, so it holds under backpressure like the beat itself.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      par_q <= 1'b0;
    end else begin
      par_q <= ^data_d;
    end
  end

  assign out_par = par_q;
`endif

  assign out_data  = data_q;
  assign out_ch    = ch_q;
  assign out_valid = valid_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mux_nto1_scan.sv
// Directed, table-driven bench for mux_nto1_scan (32-channel and 5-channel instances).
module tb_mux_nto1_scan;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 32-channel instance
  logic         rst_n;
  logic [255:0] din;
  logic         mode, start, out_ready;
  logic [4:0]   sel_in;
  logic [7:0]   out_data;
  logic [4:0]   out_ch;
  logic         out_valid, busy, done, err;

  // 5-channel instance
  logic [39:0]  din5;
  logic         mode5, start5, ready5;
  logic [2:0]   sel5;
  logic [7:0]   data5;
  logic [2:0]   ch5;
  logic         valid5, busy5, done5, err5;

`ifdef MUX_SCAN_PARITY_EN
  logic out_par, par5;
`endif

  mux_nto1_scan #(.NUM_CH(32), .DATA_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .mode      (mode),
    .sel_in    (sel_in),
    .start     (start),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done),
    .err       (err)
`ifdef MUX_SCAN_PARITY_EN
    ,
    .out_par   (out_par)
`endif
  );

  mux_nto1_scan #(.NUM_CH(5), .DATA_W(8)) dut5 (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din5),
    .mode      (mode5),
    .sel_in    (sel5),
    .start     (start5),
    .out_data  (data5),
    .out_ch    (ch5),
    .out_valid (valid5),
    .out_ready (ready5),
    .busy      (busy5),
    .done      (done5),
    .err       (err5)
`ifdef MUX_SCAN_PARITY_EN
    ,
    .out_par   (par5)
`endif
  );

  typedef struct {
    logic       mode;
    logic [4:0] sel;
    logic       start;
    logic       ready;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic [4:0] exp_ch;
    logic       exp_busy;
    logic       exp_done;
  } vec_t;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_din();
    for (int k = 0; k < 32; k++) din[k*8 +: 8] = 8'(8'hA0 + k);
    for (int k = 0; k < 5; k++) din5[k*8 +: 8] = 8'(8'hA0 + k);
  endtask

  vec_t vecs[8];

  initial begin
    bit got_done;

    rst_n = 1'b0; mode = 1'b0; sel_in = '0; start = 1'b0; out_ready = 1'b0;
    mode5 = 1'b0; sel5 = '0; start5 = 1'b0; ready5 = 1'b0;
    fill_din();
    step(); step();

    // Reset state
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_ch", 32'(out_ch), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst5_busy", 32'(busy5), 0);
    rst_n = 1'b1;
    step();

    // Manual-mode table, including a start on the same cycle done is high
    //             mode  sel    st    rdy   vld   data    ch     busy  done
    vecs[0] = '{1'b0, 5'd5,  1'b1, 1'b1, 1'b1, 8'hA5, 5'd5,  1'b1, 1'b0};
    vecs[1] = '{1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 8'h00, 5'd0,  1'b0, 1'b1};
    vecs[2] = '{1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 8'h00, 5'd0,  1'b0, 1'b0};
    vecs[3] = '{1'b0, 5'd31, 1'b1, 1'b0, 1'b1, 8'hBF, 5'd31, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 5'd2,  1'b0, 1'b0, 1'b1, 8'hBF, 5'd31, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 8'h00, 5'd0,  1'b0, 1'b1};
    vecs[6] = '{1'b0, 5'd0,  1'b1, 1'b1, 1'b1, 8'hA0, 5'd0,  1'b1, 1'b0};
    vecs[7] = '{1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 8'h00, 5'd0,  1'b0, 1'b1};
    for (int i = 0; i < 8; i++) begin
      mode = vecs[i].mode; sel_in = vecs[i].sel;
      start = vecs[i].start; out_ready = vecs[i].ready;
      step();
      chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
      chk($sformatf("v%0d_done", i), 32'(done), 32'(vecs[i].exp_done));
      chk($sformatf("v%0d_err", i), 32'(err), 0);
      if (vecs[i].exp_valid) begin
        chk($sformatf("v%0d_data", i), 32'(out_data), 32'(vecs[i].exp_data));
        chk($sformatf("v%0d_ch", i), 32'(out_ch), 32'(vecs[i].exp_ch));
      end
    end
    start = 1'b0;
    step();

    // Backpressure and snapshot: scan start, ready low, din change and a second start
    mode = 1'b1; start = 1'b1; out_ready = 1'b0;
    step();
    start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) din[7:0] = 8'h00;
      if (c == 2) begin mode = 1'b0; sel_in = 5'd9; start = 1'b1; end
      step();
      start = 1'b0;
      chk($sformatf("bp%0d_valid", c), 32'(out_valid), 1);
      chk($sformatf("bp%0d_data", c), 32'(out_data), 32'hA0);
      chk($sformatf("bp%0d_ch", c), 32'(out_ch), 0);
    end
    fill_din();
    out_ready = 1'b1;
    step();
    chk("bp_next_ch", 32'(out_ch), 1);
    chk("bp_next_data", 32'(out_data), 32'hA1);
    for (int c = 0; c < 31; c++) step();
    chk("bp_end_done", 32'(done), 1);
    chk("bp_end_valid", 32'(out_valid), 0);

    // Full scan with ready held high: 32 back-to-back beats
    mode = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 32; k++) begin
      if (out_valid !== 1'b1 || out_ch !== 5'(k) || out_data !== 8'(8'hA0 + k) || done !== 1'b0)
        chk($sformatf("scan_beat%0d", k), {out_valid, done, 6'(out_ch), out_data},
            {1'b1, 1'b0, 6'(k), 8'(8'hA0 + k)});
      else
        chk($sformatf("scan_beat%0d", k), 32'(out_ch), 32'(k));
      step();
    end
    chk("scan_done", 32'(done), 1);
    chk("scan_valid_off", 32'(out_valid), 0);
    step();
    chk("scan_busy_after", 32'(busy), 0);
    chk("scan_done_pulse", 32'(done), 0);

    // 5-channel instance: out-of-range manual select, in-range select, short scan
    mode5 = 1'b0; sel5 = 3'd6; start5 = 1'b1; ready5 = 1'b1;
    step();
    start5 = 1'b0;
    chk("err5_pulse", 32'(err5), 1);
    chk("err5_valid", 32'(valid5), 0);
    chk("err5_busy", 32'(busy5), 0);
    step();
    chk("err5_clear", 32'(err5), 0);
    chk("err5_busy2", 32'(busy5), 0);
    sel5 = 3'd4; start5 = 1'b1;
    step();
    start5 = 1'b0;
    chk("m5_data", 32'(data5), 32'hA4);
    chk("m5_err", 32'(err5), 0);
    step();
    mode5 = 1'b1; start5 = 1'b1;
    step();
    start5 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("s5_ch%0d", k), 32'(ch5), 32'(k));
      chk($sformatf("s5_data%0d", k), 32'(data5), 32'(8'hA0 + k));
      step();
    end
    chk("s5_done", 32'(done5), 1);
    chk("s5_valid", 32'(valid5), 0);

    // Reset in the middle of a scan
    step();
    mode = 1'b1; start = 1'b1; out_ready = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 10; c++) step();
    chk("mid_ch10", 32'(out_ch), 10);
    rst_n = 1'b0;
    step();
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_data", 32'(out_data), 0);
    chk("mid_rst_ch", 32'(out_ch), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_done", 32'(done), 0);
    rst_n = 1'b1; start = 1'b1; out_ready = 1'b0;
    step();
    start = 1'b0;
    chk("restart_ch", 32'(out_ch), 0);
    chk("restart_data", 32'(out_data), 32'hA0);
    chk("restart_valid", 32'(out_valid), 1);
    out_ready = 1'b1;
    got_done = 1'b0;
    for (int c = 0; c < 40 && !got_done; c++) begin
      step();
      if (done) got_done = 1'b1;
    end
    chk("restart_done_seen", 32'(got_done), 1);

`ifdef MUX_SCAN_PARITY_EN
    step();
    mode = 1'b0; sel_in = 5'd7; start = 1'b1; out_ready = 1'b0;
    step();
    start = 1'b0;
    chk("par_ch7", 32'(out_par), 1);
    step();
    chk("par_hold", 32'(out_par), 1);
    out_ready = 1'b1;
    step();
    sel_in = 5'd3; start = 1'b1;
    step();
    start = 1'b0;
    chk("par_ch3", 32'(out_par), 0);
    step();
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
